arriskv_mem_arbiter: RTL

Shares the core's single memory port between instruction fetch (IF) and the load/store stage (LS), which issues LB/LH/LW/LBU/LHU/SB/SH/SW.
- Supports one outstanding transaction at a time.
- LS has priority; a bounded starvation guard keeps fetch from being blocked indefinitely.
- The response is routed back to whichever requester owns the transaction.
- Sits between the fetch/LSU pipeline stages and the external memory interface.

---
 rtl/arriskv_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/arriskv_mem_arbiter.sv
// Two-requester memory port arbiter: load/store has priority over instruction fetch,
// with a starvation guard. One outstanding transaction; the response goes to its owner.
module arriskv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;
    mem_cmd_t          cmd_q;
    mem_cmd_t          ls_cmd;
    mem_cmd_t          if_cmd;
    logic              pick_ls;
    logic              pick_if;
    logic              starved;
    logic              rsp_ok;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
    assign pick_ls = ls_req_i && !(if_req_i && starved);
    assign pick_if = if_req_i && !pick_ls;

    assign ls_cmd = '{we: ls_we_i, be: ls_be_i, addr: ls_addr_i, wdata: ls_wdata_i};
    assign if_cmd = '{we: 1'b0, be: {BE_W{1'b1}}, addr: if_addr_i, wdata: '0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            mem_req_o  <= 1'b0;
            cmd_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ls) begin
                        owner     <= OWN_LS;
                        cmd_q     <= ls_cmd;
                        mem_req_o <= 1'b1;
                        state     <= REQ;
                        // Only LS wins over a waiting fetch count toward starvation.
                        if (if_req_i && !starved)
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end else if (pick_if) begin
                        owner      <= OWN_IF;
                        cmd_q      <= if_cmd;
                        mem_req_o  <= 1'b1;
                        state      <= REQ;
                        starve_cnt <= '0;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_we_o    = cmd_q.we;
    assign mem_be_o    = cmd_q.be;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;

    assign if_gnt_o = (state == IDLE) && pick_if;
    assign ls_gnt_o = (state == IDLE) && pick_ls;
    assign busy_o   = (state != IDLE);

    // Responses outside WAIT_RSP are spurious and never routed.
    assign rsp_ok      = (state == WAIT_RSP) && mem_rvalid_i;
    assign if_rvalid_o = rsp_ok && (owner == OWN_IF);
    assign ls_rvalid_o = rsp_ok && (owner == OWN_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

endmodule
